instruction_fetch: RTL and testbench

Fetch unit that supplies the instruction register: generates word addresses into instruction memory, buffers returned 16-bit words in a small prefetch FIFO, and presents them as `Instr` with a one-cycle `IW` write strobe when control asks for the next instruction. It sits between instruction memory and the instruction register / decoder and is the producer end of the `Instr`/`IW` interface. Control redirects it on taken branches and jumps.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instruction_fetch.sv | 131 +++++++++++++
 tb/tb_instruction_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch-unit state encoding.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {fetch address, instruction word} pairs.
// Flush empties the queue and wins over a same-cycle push or pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ADDR_W + INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a prefetch
// FIFO, drained into the instruction register on Next, flushed on Redirect.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               CLK,
    input  logic               RESET_N,
    output logic               MemReq,
    output logic [ADDR_W-1:0]  MemAddr,
    input  logic               MemGnt,
    input  logic               MemValid,
    input  logic [INSTR_W-1:0] MemData,
    input  logic               Next,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  Target,
    output logic [INSTR_W-1:0] Instr,
    output logic               IW,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               Stall
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    fetch_state_t                state;
    logic [ADDR_W-1:0]           fetch_pc;
    logic [ADDR_W-1:0]           req_addr;
    logic [CW-1:0]               fifo_count;
    logic [CW-1:0]               count_nx;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [ADDR_W+INSTR_W-1:0]   head;
    logic                        granted;
    logic                        push;
    logic                        pop;
    logic                        room;

    assign MemAddr = fetch_pc;
    assign granted = MemReq && MemGnt;
    assign pop     = Next && !fifo_empty && !Redirect;
    assign push    = (state == ST_WAIT) && MemValid && !Redirect && !fifo_full;
    assign Stall   = Next && fifo_empty;

    // Occupancy after this cycle; a new request is only issued if it still fits.
    always_comb begin
        count_nx = fifo_count;
        if (Redirect)          count_nx = '0;
        else if (push && !pop) count_nx = fifo_count + 1'b1;
        else if (pop && !push) count_nx = fifo_count - 1'b1;
    end

    assign room = (count_nx < DEPTH_CNT);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (push),
        .pop   (pop),
        .flush (Redirect),
        .din   ({req_addr, MemData}),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            MemReq   <= 1'b0;
        end else begin
            if (Redirect)     fetch_pc <= Target;
            else if (granted) fetch_pc <= fetch_pc + 1'b1;
            if (granted) req_addr <= fetch_pc;

            case (state)
                ST_IDLE: begin
                    state  <= ST_REQ;
                    MemReq <= room;
                end
                ST_REQ: begin
                    // A request granted together with a redirect is already stale.
                    if (granted) begin
                        state  <= Redirect ? ST_DROP : ST_WAIT;
                        MemReq <= 1'b0;
                    end else begin
                        MemReq <= room;
                    end
                end
                ST_WAIT: begin
                    if (MemValid) begin
                        state  <= ST_REQ;
                        MemReq <= room;
                    end else if (Redirect) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (MemValid) begin
                        state  <= ST_REQ;
                        MemReq <= room;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    MemReq <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Instr   <= '0;
            InstrPC <= '0;
            IW      <= 1'b0;
        end else begin
            IW <= pop;
            if (pop) {InstrPC, Instr} <= head;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-programmable memory model.
module tb_instruction_fetch;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemGnt;
    logic        MemValid;
    logic [15:0] MemData;
    logic        Next = 1'b0;
    logic        Redirect = 1'b0;
    logic [15:0] Target = 16'h0000;
    logic [15:0] Instr;
    logic        IW;
    logic [15:0] InstrPC;
    logic        Stall;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    logic [15:0] grant_q [$];
    logic [31:0] iw_q [$];

    always #5 CLK = ~CLK;

    instruction_fetch #(.DEPTH(2), .RESET_PC(16'h0010)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemGnt(MemGnt), .MemValid(MemValid), .MemData(MemData),
        .Next(Next), .Redirect(Redirect), .Target(Target),
        .Instr(Instr), .IW(IW), .InstrPC(InstrPC), .Stall(Stall)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory: grants every request, answers after lat cycles, shares RESET_N.
    assign MemGnt = MemReq;
    logic        pend;
    logic [15:0] paddr;
    int          pcnt;
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend <= 1'b0; pcnt <= 0; paddr <= 16'h0; MemValid <= 1'b0; MemData <= 16'h0;
        end else begin
            MemValid <= 1'b0;
            if (pend) begin
                if (pcnt <= 1) begin
                    MemValid <= 1'b1; MemData <= memf(paddr); pend <= 1'b0;
                end else pcnt <= pcnt - 1;
            end
            if (MemReq && MemGnt) begin
                if (lat <= 1) begin
                    MemValid <= 1'b1; MemData <= memf(MemAddr);
                end else begin
                    pend <= 1'b1; paddr <= MemAddr; pcnt <= lat - 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (MemReq && MemGnt) grant_q.push_back(MemAddr);
        if (IW) iw_q.push_back({InstrPC, Instr});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge CLK); #1; end
    endtask

    task automatic do_reset(input int l, input logic nx);
        lat = l; Next = nx; Redirect = 1'b0; Target = 16'h0;
        RESET_N = 1'b0;
        tick(2);
        grant_q.delete(); iw_q.delete();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        lat = 1; Next = 1'b0; Redirect = 1'b0; Target = 16'h0;
        RESET_N = 1'b0;
        tick(2);
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL reset_memreq: got %b want 0", MemReq); end
        checks++; if (IW !== 1'b0) begin errors++; $display("FAIL reset_iw: got %b want 0", IW); end
        checks++; if (Instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", Instr); end
        checks++; if (InstrPC !== 16'h0000) begin errors++; $display("FAIL reset_instrpc: got %h want 0000", InstrPC); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
        RESET_N = 1'b1;
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL idle_memreq: got %b want 0", MemReq); end
        tick();
        checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL first_memreq: got %b want 1", MemReq); end
        checks++; if (MemAddr !== 16'h0010) begin errors++; $display("FAIL first_memaddr: got %h want 0010", MemAddr); end
    endtask

    task automatic test_fetch_sequence();
        do_reset(1, 1'b1);
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL seq_stall_empty: got %b want 1", Stall); end
        tick(12);
        checks++;
        if (grant_q.size() < 3) begin
            errors++; $display("FAIL seq_grant_count: got %0d want >=3", grant_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (grant_q[k] !== 16'h0010 + 16'(k)) begin
                    errors++; $display("FAIL seq_memaddr%0d: got %h want %h", k, grant_q[k], 16'h0010 + 16'(k));
                end
            end
        end
        checks++;
        if (iw_q.size() < 2) begin
            errors++; $display("FAIL seq_iw_count: got %0d want >=2", iw_q.size());
        end else begin
            checks++; if (iw_q[0] !== {16'h0010, 16'hC3B5}) begin errors++; $display("FAIL seq_iw0: got %h want %h", iw_q[0], {16'h0010, 16'hC3B5}); end
            checks++; if (iw_q[1] !== {16'h0011, 16'hC3B4}) begin errors++; $display("FAIL seq_iw1: got %h want %h", iw_q[1], {16'h0011, 16'hC3B4}); end
        end
        Next = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0);
        tick(10);
        checks++; if (grant_q.size() != 2) begin errors++; $display("FAIL bp_grant_count: got %0d want 2", grant_q.size()); end
        else begin
            checks++; if (grant_q[1] !== 16'h0011) begin errors++; $display("FAIL bp_grant1: got %h want 0011", grant_q[1]); end
        end
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL bp_memreq_full: got %b want 0", MemReq); end
        checks++; if (iw_q.size() != 0) begin errors++; $display("FAIL bp_no_iw: got %0d want 0", iw_q.size()); end
        Next = 1'b1;
        tick(8);
        Next = 1'b0;
        checks++;
        if (iw_q.size() < 3 || grant_q.size() < 3) begin
            errors++; $display("FAIL bp_drain_count: got iw %0d grants %0d want >=3 each", iw_q.size(), grant_q.size());
        end else begin
            checks++; if (iw_q[0] !== {16'h0010, 16'hC3B5}) begin errors++; $display("FAIL bp_iw0: got %h want %h", iw_q[0], {16'h0010, 16'hC3B5}); end
            checks++; if (iw_q[1] !== {16'h0011, 16'hC3B4}) begin errors++; $display("FAIL bp_iw1: got %h want %h", iw_q[1], {16'h0011, 16'hC3B4}); end
            checks++; if (iw_q[2] !== {16'h0012, 16'hC3B7}) begin errors++; $display("FAIL bp_iw2: got %h want %h", iw_q[2], {16'h0012, 16'hC3B7}); end
            checks++; if (grant_q[2] !== 16'h0012) begin errors++; $display("FAIL bp_resume_addr: got %h want 0012", grant_q[2]); end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset(3, 1'b0);
        tick(2);
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL rw_wait_memreq: got %b want 0", MemReq); end
        Redirect = 1'b1; Target = 16'h0200;
        tick();
        Redirect = 1'b0; Next = 1'b1;
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL rw_drop_memreq: got %b want 0", MemReq); end
        tick(14);
        Next = 1'b0;
        checks++;
        if (grant_q.size() < 2) begin
            errors++; $display("FAIL rw_grant_count: got %0d want >=2", grant_q.size());
        end else begin
            checks++; if (grant_q[1] !== 16'h0200) begin errors++; $display("FAIL rw_target_addr: got %h want 0200", grant_q[1]); end
        end
        checks++;
        if (iw_q.size() < 1) begin
            errors++; $display("FAIL rw_iw_count: got %0d want >=1", iw_q.size());
        end else begin
            checks++; if (iw_q[0] !== {16'h0200, 16'hC1A5}) begin errors++; $display("FAIL rw_first_iw: got %h want %h", iw_q[0], {16'h0200, 16'hC1A5}); end
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1, 1'b0);
        tick(8);
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL rf_full_memreq: got %b want 0", MemReq); end
        Next = 1'b1; Redirect = 1'b1; Target = 16'h0300;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rf_stall_nonempty: got %b want 0", Stall); end
        tick();
        Redirect = 1'b0;
        checks++; if (IW !== 1'b0) begin errors++; $display("FAIL rf_iw_after_redirect: got %b want 0", IW); end
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL rf_stall_flushed: got %b want 1", Stall); end
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'h0300) begin errors++; $display("FAIL rf_refetch: got %b/%h want 1/0300", MemReq, MemAddr); end
        tick();
        checks++; if (IW !== 1'b0 || Stall !== 1'b1) begin errors++; $display("FAIL rf_still_empty: got iw %b stall %b want 0 1", IW, Stall); end
        Next = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b0);
        tick(8);
        Redirect = 1'b1; Target = 16'hFFFF;
        grant_q.delete();
        tick();
        Redirect = 1'b0;
        checks++; if (MemAddr !== 16'hFFFF) begin errors++; $display("FAIL wrap_target: got %h want FFFF", MemAddr); end
        tick(4);
        checks++;
        if (grant_q.size() < 2) begin
            errors++; $display("FAIL wrap_grant_count: got %0d want >=2", grant_q.size());
        end else begin
            checks++; if (grant_q[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_grant0: got %h want FFFF", grant_q[0]); end
            checks++; if (grant_q[1] !== 16'h0000) begin errors++; $display("FAIL wrap_grant1: got %h want 0000", grant_q[1]); end
        end
        iw_q.delete();
        Next = 1'b1;
        tick(6);
        Next = 1'b0;
        checks++;
        if (iw_q.size() < 2) begin
            errors++; $display("FAIL wrap_iw_count: got %0d want >=2", iw_q.size());
        end else begin
            checks++; if (iw_q[0] !== {16'hFFFF, 16'h3C5A}) begin errors++; $display("FAIL wrap_iw0: got %h want %h", iw_q[0], {16'hFFFF, 16'h3C5A}); end
            checks++; if (iw_q[1] !== {16'h0000, 16'hC3A5}) begin errors++; $display("FAIL wrap_iw1: got %h want %h", iw_q[1], {16'h0000, 16'hC3A5}); end
        end
    endtask

    task automatic test_async_reset();
        do_reset(3, 1'b1);
        for (int i = 0; i < 40 && !(iw_q.size() >= 1 && MemReq === 1'b0); i++) tick();
        checks++;
        if (!(iw_q.size() >= 1 && MemReq === 1'b0)) begin
            errors++; $display("FAIL ar_reach_wait: got iw %0d memreq %b want >=1 and 0", iw_q.size(), MemReq);
        end
        checks++; if (Instr !== 16'hC3B5) begin errors++; $display("FAIL ar_pre_instr: got %h want C3B5", Instr); end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL ar_memreq: got %b want 0", MemReq); end
        checks++; if (IW !== 1'b0) begin errors++; $display("FAIL ar_iw: got %b want 0", IW); end
        checks++; if (Instr !== 16'h0000) begin errors++; $display("FAIL ar_instr: got %h want 0000", Instr); end
        checks++; if (InstrPC !== 16'h0000) begin errors++; $display("FAIL ar_instrpc: got %h want 0000", InstrPC); end
        tick();
        grant_q.delete(); iw_q.delete();
        RESET_N = 1'b1;
        tick();
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'h0010) begin errors++; $display("FAIL ar_restart: got %b/%h want 1/0010", MemReq, MemAddr); end
        tick(12);
        Next = 1'b0;
        checks++;
        if (iw_q.size() < 1) begin
            errors++; $display("FAIL ar_iw_count: got %0d want >=1", iw_q.size());
        end else begin
            checks++; if (iw_q[0] !== {16'h0010, 16'hC3B5}) begin errors++; $display("FAIL ar_first_iw: got %h want %h", iw_q[0], {16'h0010, 16'hC3B5}); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_sequence();
        test_backpressure();
        test_redirect_wait();
        test_redirect_full();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
